// File: rtl/adder_accum_ctrl.sv
// adder_accum_ctrl: accumulator/operand front end for the 16-bit lab adders.
// Optional macro ADDER_ACCUM_SIGNED_OVF_EN adds a sticky signed-overflow output Ovf.
module adder_accum_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] SW,
  input  logic [WIDTH-1:0] Add_S,
  input  logic             Add_Cout,
  output logic [WIDTH-1:0] Add_A,
  output logic [WIDTH-1:0] Add_B,
  output logic             Add_Cin,
  output logic [WIDTH-1:0] Acc,
  output logic             Cout_Sticky,
  output logic             Busy,
  output logic             Done
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
  ,
  output logic             Ovf
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic             sticky_q, sticky_d;
  logic             done_q, done_d;
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
  logic             ovf_hit;
`endif

  // State and datapath registers; synchronous reset aborts any add.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      breg_q   <= '0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      breg_q   <= breg_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

`ifdef ADDER_ACCUM_SIGNED_OVF_EN
  // Two like-signed operands giving a differently-signed sum.
  always_comb begin
    ovf_hit = (acc_q[WIDTH-1] == breg_q[WIDTH-1]) &&
              (Add_S[WIDTH-1] != acc_q[WIDTH-1]);
  end
`endif

  // Next-state logic: one add per Run assertion, held Run parks in HOLD.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    breg_d   = breg_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Run) begin
          breg_d  = SW;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end else if (ClearA_LoadB) begin
          acc_d    = '0;
          breg_d   = SW;
          sticky_d = 1'b0;
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        acc_d    = Add_S;
        sticky_d = sticky_q | Add_Cout;
        done_d   = 1'b1;
        state_d  = HOLD;
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
        ovf_d    = ovf_q | ovf_hit;
`endif
      end
      HOLD: begin
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Continuous adder drive and status outputs.
  always_comb begin
    Add_A       = acc_q;
    Add_B       = breg_q;
    Add_Cin     = 1'b0;
    Acc         = acc_q;
    Cout_Sticky = sticky_q;
    Done        = done_q;
    Busy        = (state_q == SETTLE) || (state_q == CAPTURE);
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
    Ovf         = ovf_q;
`endif
  end

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// tb_adder_accum_ctrl: table vectors, corner sequences and random ops
// against a transaction-level accumulator model.
module tb_adder_accum_ctrl;
  localparam int W = 16;
  localparam int S = 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Run = 1'b0;
  logic         ClearA_LoadB = 1'b0;
  logic [W-1:0] SW = '0;
  logic [W-1:0] Add_S;
  logic         Add_Cout;
  logic [W-1:0] Add_A, Add_B, Acc;
  logic         Add_Cin, Cout_Sticky, Busy, Done;
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
  logic         Ovf;
`endif

  int checks = 0;
  int failures = 0;

  // Model reference state.
  logic [W-1:0] m_acc;
  logic         m_sticky;
  logic         m_ovf;

  always #5 Clk = ~Clk;

  // Behavioural stand-in for the combinational adder.
  always_comb begin
    {Add_Cout, Add_S} = {1'b0, Add_A} + {1'b0, Add_B} + {16'd0, Add_Cin};
  end

  adder_accum_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .SW(SW), .Add_S(Add_S), .Add_Cout(Add_Cout),
    .Add_A(Add_A), .Add_B(Add_B), .Add_Cin(Add_Cin),
    .Acc(Acc), .Cout_Sticky(Cout_Sticky), .Busy(Busy), .Done(Done)
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_clear(input logic [W-1:0] sw);
    ClearA_LoadB = 1'b1;
    SW = sw;
    tick();
    ClearA_LoadB = 1'b0;
    m_acc = '0;
    m_sticky = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Run held for 'hold' edges; reports Busy/Done cycle counts and Acc
  // just before and just after the expected capture edge.
  task automatic do_add(input logic [W-1:0] sw, input int hold,
                        output int bn, output int dn,
                        output logic [W-1:0] a_pre,
                        output logic [W-1:0] a_post);
    logic [W:0] s;
    Run = 1'b1;
    SW = sw;
    bn = 0;
    dn = 0;
    a_pre = '0;
    a_post = '0;
    for (int c = 0; c < hold + S + 3; c++) begin
      tick();
      if (c == hold - 1) Run = 1'b0;
      if (Busy) bn++;
      if (Done) dn++;
      if (c == S) a_pre = Acc;
      if (c == S + 1) a_post = Acc;
    end
    s = {1'b0, m_acc} + {1'b0, sw};
    if (m_acc[W-1] == sw[W-1] && s[W-1] != m_acc[W-1]) m_ovf = 1'b1;
    m_acc = s[W-1:0];
    m_sticky = m_sticky | s[W];
  endtask

  typedef struct {
    bit           clr;
    logic [W-1:0] sw;
    int           hold;
    logic [W-1:0] exp_acc;
    bit           exp_sticky;
  } vec_t;

  vec_t vt[10];

  initial begin
    int bn, dn;
    logic [W-1:0] ap, aq, prev;
    m_acc = '0;
    m_sticky = 1'b0;
    m_ovf = 1'b0;

    vt[0] = '{1'b1, 16'h0000, 0, 16'h0000, 1'b0};
    vt[1] = '{1'b0, 16'h1234, 1, 16'h1234, 1'b0};
    vt[2] = '{1'b0, 16'h0001, 10, 16'h1235, 1'b0};
    vt[3] = '{1'b0, 16'h0001, 1, 16'h1236, 1'b0};
    vt[4] = '{1'b1, 16'hFFFF, 0, 16'h0000, 1'b0};
    vt[5] = '{1'b0, 16'hFFFF, 2, 16'hFFFF, 1'b0};
    vt[6] = '{1'b0, 16'h0002, 1, 16'h0001, 1'b1};
    vt[7] = '{1'b1, 16'h0007, 0, 16'h0000, 1'b0};
    vt[8] = '{1'b0, 16'h8000, 3, 16'h8000, 1'b0};
    vt[9] = '{1'b0, 16'h8000, 1, 16'h0000, 1'b1};

    tick();
    tick();
    Reset = 1'b0;
    chk("rst_acc", 32'(Acc), 32'h0);
    chk("rst_b", 32'(Add_B), 32'h0);
    chk("rst_sticky", 32'(Cout_Sticky), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("cin", 32'(Add_Cin), 32'h0);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].clr) begin
        do_clear(vt[i].sw);
      end else begin
        prev = m_acc;
        do_add(vt[i].sw, vt[i].hold, bn, dn, ap, aq);
        chk($sformatf("v%0d_busy", i), 32'(bn), 32'(S + 1));
        chk($sformatf("v%0d_done", i), 32'(dn), 32'd1);
        chk($sformatf("v%0d_pre", i), 32'(ap), 32'(prev));
        chk($sformatf("v%0d_post", i), 32'(aq), 32'(vt[i].exp_acc));
      end
      chk($sformatf("v%0d_acc", i), 32'(Acc), 32'(vt[i].exp_acc));
      chk($sformatf("v%0d_stk", i), 32'(Cout_Sticky), 32'(vt[i].exp_sticky));
      chk($sformatf("v%0d_b", i), 32'(Add_B), 32'(vt[i].sw));
    end

    // Clear and new operand ignored while settling.
    prev = Acc;
    Run = 1'b1;
    SW = 16'h0010;
    tick();
    Run = 1'b0;
    SW = 16'hAAAA;
    ClearA_LoadB = 1'b1;
    tick();
    tick();
    ClearA_LoadB = 1'b0;
    dn = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (Done) dn++;
    end
    chk("settle_clr_acc", 32'(Acc), 32'(prev + 16'h0010));
    chk("settle_clr_b", 32'(Add_B), 32'h0010);
    chk("settle_clr_done", 32'(dn), 32'd1);
    m_acc = prev + 16'h0010;

    // Reset during SETTLE aborts the add.
    do_clear(16'h0000);
    do_add(16'h00FF, 1, bn, dn, ap, aq);
    chk("pre_rst_acc", 32'(Acc), 32'h00FF);
    Run = 1'b1;
    SW = 16'h0040;
    tick();
    Run = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_acc", 32'(Acc), 32'h0);
    chk("abort_busy", 32'(Busy), 32'h0);
    dn = 0;
    bn = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (Done) dn++;
      if (Busy) bn++;
    end
    chk("abort_done", 32'(dn), 32'd0);
    chk("abort_busy_after", 32'(bn), 32'd0);
    chk("abort_acc_after", 32'(Acc), 32'h0);
    m_acc = '0;
    m_sticky = 1'b0;
    m_ovf = 1'b0;
    do_add(16'h0003, 1, bn, dn, ap, aq);
    chk("post_abort_acc", 32'(Acc), 32'h0003);

`ifdef ADDER_ACCUM_SIGNED_OVF_EN
    do_clear(16'h0000);
    do_add(16'h7FFF, 1, bn, dn, ap, aq);
    chk("ovf_pre", 32'(Ovf), 32'h0);
    do_add(16'h0001, 1, bn, dn, ap, aq);
    chk("ovf_acc", 32'(Acc), 32'h8000);
    chk("ovf_set", 32'(Ovf), 32'h1);
    chk("ovf_stk", 32'(Cout_Sticky), 32'h0);
    do_clear(16'h0000);
    chk("ovf_clr", 32'(Ovf), 32'h0);
`endif

    // Random clears and adds against the model.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] r;
      r = W'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        do_clear(r);
      end else begin
        do_add(r, int'($urandom_range(1, 6)), bn, dn, ap, aq);
        chk($sformatf("r%0d_done", i), 32'(dn), 32'd1);
      end
      chk($sformatf("r%0d_acc", i), 32'(Acc), 32'(m_acc));
      chk($sformatf("r%0d_stk", i), 32'(Cout_Sticky), 32'(m_sticky));
      chk($sformatf("r%0d_b", i), 32'(Add_B), 32'(r));
`ifdef ADDER_ACCUM_SIGNED_OVF_EN
      chk($sformatf("r%0d_ovf", i), 32'(Ovf), 32'(m_ovf));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_accum_ctrl.md
Name: adder_accum_ctrl

Overview:
Sequential front end and result capture stage for the 16-bit lab adders (ripple, lookahead, select).
- Holds an accumulator and an operand register and drives the adder's A/B/cin inputs.
- On a Run request, waits a fixed settle interval for the combinational adder, then captures its sum and carry back into the accumulator.
- Sits between the switch/button inputs and the adder; Acc feeds the hex display.

Parameters:
WIDTH, 16, datapath width; must match the adder.
SETTLE_CYCLES, 2, cycles the adder inputs are held stable before capture; legal range 1..15.

Ports:
Clk  in  1  system clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
Run  in  1  level request, already debounced/synchronized; one add per assertion.
ClearA_LoadB  in  1  level; clears accumulator and sticky flags, loads SW into operand register.
SW  in  WIDTH  operand source.
Add_S  in  WIDTH  sum from adder.
Add_Cout  in  1  carry-out from adder.
Add_A  out  WIDTH  adder A input; equals Acc.
Add_B  out  WIDTH  adder B input; equals operand register Breg.
Add_Cin  out  1  adder carry-in; tied 0.
Acc  out  WIDTH  accumulator value.
Cout_Sticky  out  1  OR of all captured carries since last clear.
Busy  out  1  high in SETTLE and CAPTURE.
Done  out  1  one-cycle pulse after each capture.

Behaviour:
- Reset (synchronous, active-high):
  - Acc=0, Breg=0, Cout_Sticky=0, Done=0, Busy=0.
  - State=IDLE, settle counter=0.
  - Dominates all other inputs; any operation in progress is aborted with no capture and no Done.
- Add_A/Add_B/Add_Cin are continuous: Acc, Breg, 0.
- States:
  - IDLE:
    - Run=1: Breg<=SW; cnt<=SETTLE_CYCLES-1; go SETTLE.
    - Run=0 and ClearA_LoadB=1: Acc<=0, Breg<=SW, Cout_Sticky<=0; stay IDLE.
    - Run has priority over ClearA_LoadB when both are high.
  - SETTLE:
    - Breg and Acc frozen; SW and ClearA_LoadB ignored.
    - cnt!=0: cnt<=cnt-1.
    - cnt==0: go CAPTURE.
  - CAPTURE (one cycle): Acc<=Add_S; Cout_Sticky<=Cout_Sticky|Add_Cout; Done<=1; go HOLD.
  - HOLD: Done<=0 after its single cycle; stay while Run=1; Run=0 goes IDLE. A held Run never re-triggers an add.
- Latency: Run sampled at edge k gives
  - Breg load at edge k;
  - CAPTURE entered at edge k+SETTLE_CYCLES;
  - Acc update at edge k+SETTLE_CYCLES+1;
  - Done high for the cycle following that edge.
- Arithmetic: Acc wraps modulo 2^WIDTH; carry is recorded only in Cout_Sticky.
- Run falling during SETTLE: the add still completes; state goes HOLD then IDLE on the next cycle.
- SETTLE_CYCLES outside 1..15: elaboration-time error.

Optional Feature:
Macro ADDER_ACCUM_SIGNED_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit).
  - At CAPTURE: Ovf<=Ovf | (Acc[WIDTH-1]==Breg[WIDTH-1] && Add_S[WIDTH-1]!=Acc[WIDTH-1]).
  - Cleared by Reset and by ClearA_LoadB in IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset; ClearA_LoadB with SW=0x0000; Run one cycle with SW=0x1234, SETTLE_CYCLES=2 -> Acc=0x1234 at edge k+3; Done high exactly 1 cycle; Cout_Sticky=0; Busy high 3 cycles.
2. Acc=0x1234; Run held 10 cycles with SW=0x0001 -> exactly one add; Acc=0x1235; single Done pulse; second Run assertion -> Acc=0x1236.
3. Acc=0xFFFF; Run with SW=0x0002 -> Acc=0x0001, Cout_Sticky=1; then ClearA_LoadB with SW=0x0007 -> Acc=0, Breg=0x0007, Cout_Sticky=0.
4. Run with SW=0x0010, then SW=0xAAAA and ClearA_LoadB=1 during SETTLE -> Acc=prev+0x0010; clear ignored.
5. Reset asserted in the SETTLE cycle after Acc=0x00FF -> Acc=0, Busy=0, no Done; next Run with SW=0x0003 -> Acc=0x0003.
6. With ADDER_ACCUM_SIGNED_OVF_EN: Acc=0x7FFF, Run with SW=0x0001 -> Acc=0x8000, Ovf=1, Cout_Sticky=0; ClearA_LoadB -> Ovf=0.
